// File: rtl/alu_pool_scheduler_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_pool_scheduler_pkg : shared types for the ALU pool scheduler            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pool_scheduler_pkg;

  localparam int DATA_W = 32;
  localparam int FUNC_W = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_func_e;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_LAUNCH = 2'd1,
    SLOT_BUSY   = 2'd2,
    SLOT_DRAIN  = 2'd3
  } slot_state_e;

  // Pointer width that stays legal for a single-entry pool.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_pool_scheduler_arbiter.sv
// +----------------------------------------------------------------------------+
// | alu_rr_arbiter : combinational round-robin grant starting at ptr            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_rr_arbiter
  import alu_pool_scheduler_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_ix
);

  logic found;
  int   j;

  always_comb begin
    grant    = '0;
    grant_ix = '0;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        grant_ix = PTR_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_pool_scheduler.sv
// +----------------------------------------------------------------------------+
// | alu_pool_scheduler : issues ready ops onto an ALU pool, round-robin CDB     |
// | Optional macro ALU_POOL_SCHED_PERF_EN adds issue/stall counters.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_pool_scheduler
  import alu_pool_scheduler_pkg::*;
#(
  parameter int NUM_ALU = 4,
  parameter int ROB_IX  = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        flush_in,
  input  logic                        issue_valid_in,
  output logic                        issue_ready_out,
  input  logic [DATA_W-1:0]           issue_rval1_in,
  input  logic [DATA_W-1:0]           issue_rval2_in,
  input  logic [FUNC_W-1:0]           issue_func_in,
  input  logic [ROB_IX:0]             issue_rob_ix_in,
  output logic [NUM_ALU-1:0]          alu_valid_out,
  output logic [NUM_ALU-1:0]          alu_read_out,
  output logic [DATA_W*NUM_ALU-1:0]   alu_rval1_out,
  output logic [DATA_W*NUM_ALU-1:0]   alu_rval2_out,
  output logic [FUNC_W*NUM_ALU-1:0]   alu_func_out,
  input  logic [NUM_ALU-1:0]          alu_ready_in,
  input  logic [NUM_ALU-1:0]          alu_valid_in,
  input  logic [DATA_W*NUM_ALU-1:0]   alu_data_in,
  output logic                        cdb_valid_out,
  input  logic                        cdb_ready_in,
  output logic [DATA_W-1:0]           cdb_data_out,
  output logic [ROB_IX:0]             cdb_rob_ix_out
`ifdef ALU_POOL_SCHED_PERF_EN
  ,
  output logic [31:0]                 perf_issued_out,
  output logic [31:0]                 perf_stall_out
`endif
);

  localparam int PTR_W = ptr_width(NUM_ALU);
  localparam int TAG_W = ROB_IX + 1;

  logic                     kill;
  logic [NUM_ALU-1:0]       eligible;
  logic [NUM_ALU-1:0]       cand;
  logic [NUM_ALU-1:0]       issue_sel;
  logic [NUM_ALU-1:0]       cdb_grant;
  logic [PTR_W-1:0]         cdb_grant_ix;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_ALU*TAG_W-1:0] tag_flat;
  logic                     issue_fire;
  logic                     cdb_fire;
  logic                     sel_found;

  // Reset and flush both suppress every handshake in the cycle they are seen.
  assign kill            = rst_in | flush_in;
  assign issue_ready_out = (|eligible) & ~kill;
  assign issue_fire      = issue_valid_in & issue_ready_out;
  assign cdb_valid_out   = (|cand) & ~kill;
  assign cdb_fire        = cdb_valid_out & cdb_ready_in;
  assign alu_read_out    = cdb_fire ? cdb_grant : '0;
  assign cdb_data_out    = alu_data_in[cdb_grant_ix*DATA_W +: DATA_W];
  assign cdb_rob_ix_out  = tag_flat[cdb_grant_ix*TAG_W +: TAG_W];

  always_comb begin
    issue_sel = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_ALU; i++) begin
      if (eligible[i] && !sel_found) begin
        issue_sel[i] = 1'b1;
        sel_found    = 1'b1;
      end
    end
  end

  alu_rr_arbiter #(
    .N     (NUM_ALU),
    .PTR_W (PTR_W)
  ) u_wb_arb (
    .req      (cand),
    .ptr      (rr_ptr_q),
    .grant    (cdb_grant),
    .grant_ix (cdb_grant_ix)
  );

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (cdb_fire) begin
      rr_ptr_d = (cdb_grant_ix == PTR_W'(NUM_ALU - 1)) ? '0 : cdb_grant_ix + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (kill) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_ALU; i++) begin : g_slot
      slot_state_e        state_q, state_d;
      logic [DATA_W-1:0]  rval1_q, rval1_d;
      logic [DATA_W-1:0]  rval2_q, rval2_d;
      logic [FUNC_W-1:0]  func_q, func_d;
      logic [TAG_W-1:0]   tag_q, tag_d;

      assign eligible[i]                       = (state_q == SLOT_IDLE) && alu_ready_in[i];
      assign cand[i]                           = (state_q == SLOT_BUSY) && alu_valid_in[i];
      assign alu_valid_out[i]                  = (state_q == SLOT_LAUNCH) && !kill;
      assign alu_rval1_out[i*DATA_W +: DATA_W] = rval1_q;
      assign alu_rval2_out[i*DATA_W +: DATA_W] = rval2_q;
      assign alu_func_out[i*FUNC_W +: FUNC_W]  = func_q;
      assign tag_flat[i*TAG_W +: TAG_W]        = tag_q;

      // Payload is cleared on the way back to IDLE so idle slots drive zero.
      always_comb begin
        state_d = state_q;
        rval1_d = rval1_q;
        rval2_d = rval2_q;
        func_d  = func_q;
        tag_d   = tag_q;
        case (state_q)
          SLOT_IDLE: begin
            if (issue_fire && issue_sel[i]) begin
              state_d = SLOT_LAUNCH;
              rval1_d = issue_rval1_in;
              rval2_d = issue_rval2_in;
              func_d  = issue_func_in;
              tag_d   = issue_rob_ix_in;
            end
          end
          SLOT_LAUNCH: state_d = SLOT_BUSY;
          SLOT_BUSY: begin
            if (cdb_fire && cdb_grant[i]) state_d = SLOT_DRAIN;
          end
          SLOT_DRAIN: begin
            if (alu_ready_in[i]) begin
              state_d = SLOT_IDLE;
              rval1_d = '0;
              rval2_d = '0;
              func_d  = '0;
              tag_d   = '0;
            end
          end
          default: state_d = SLOT_IDLE;
        endcase
      end

      always_ff @(posedge clk_in) begin
        if (kill) begin
          state_q <= SLOT_IDLE;
          rval1_q <= '0;
          rval2_q <= '0;
          func_q  <= '0;
          tag_q   <= '0;
        end else begin
          state_q <= state_d;
          rval1_q <= rval1_d;
          rval2_q <= rval2_d;
          func_q  <= func_d;
          tag_q   <= tag_d;
        end
      end
    end
  endgenerate

`ifdef ALU_POOL_SCHED_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counters survive flush; only a real reset clears them.
  always_comb begin
    perf_issued_d = perf_issued_q + {31'b0, issue_fire};
    perf_stall_d  = perf_stall_q + {31'b0, issue_valid_in & ~issue_ready_out};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued_out = perf_issued_q;
  assign perf_stall_out  = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: doc/alu_pool_scheduler.md
Name: alu_pool_scheduler

Overview:
- Shares a pool of NUM_ALU `alu` instances between one dispatch stream and one common-data-bus (CDB) writeback port.
- Accepts one ready-operand instruction per cycle and launches it on a free ALU, holding the operands stable until the result is read.
- Arbitrates completed ALUs round-robin onto the CDB, then sequences each ALU's read/drain handshake.
- Sits between the reservation station and the ALU bank; the ALUs' own flush/reset are driven by the top.

Parameters:
NUM_ALU, 4, number of ALU slots managed (2..8)
ROB_IX, 2, ROB index MSB; tags are ROB_IX+1 bits wide

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
flush_in  input  1  pipeline flush; squashes all slots
issue_valid_in  input  1  dispatch request
issue_ready_out  output  1  dispatch accepted this cycle when also valid
issue_rval1_in  input  32  operand 1
issue_rval2_in  input  32  operand 2
issue_func_in  input  4  AluFunc code
issue_rob_ix_in  input  ROB_IX+1  destination ROB tag
alu_valid_out  output  NUM_ALU  per-ALU start pulse
alu_read_out  output  NUM_ALU  per-ALU result-consumed pulse
alu_rval1_out  output  32*NUM_ALU  held operand 1 per slot
alu_rval2_out  output  32*NUM_ALU  held operand 2 per slot
alu_func_out  output  4*NUM_ALU  held func per slot
alu_ready_in  input  NUM_ALU  ALU ready_out
alu_valid_in  input  NUM_ALU  ALU valid_out
alu_data_in  input  32*NUM_ALU  ALU data_out
cdb_valid_out  output  1  result available
cdb_ready_in  input  1  CDB accepts
cdb_data_out  output  32  result value
cdb_rob_ix_out  output  ROB_IX+1  result tag

Behaviour:
- Slot FSM per ALU:
  - IDLE -> LAUNCH: on issue fire to this slot.
  - LAUNCH -> BUSY: unconditional, one cycle; alu_valid_out[i]=1 only in LAUNCH.
  - BUSY -> DRAIN: on CDB fire with grant i.
  - DRAIN -> IDLE: when alu_ready_in[i]=1.
- Issue:
  - Eligible slots are IDLE with alu_ready_in=1; the lowest-index eligible slot is selected.
  - issue_ready_out = any eligible slot && !flush_in (combinational).
  - Fire = issue_valid_in && issue_ready_out.
  - On fire, latch rval1, rval2, func and rob_ix into the slot registers; they stay held unchanged until the slot returns to IDLE.
- Writeback:
  - Candidates are BUSY slots with alu_valid_in=1.
  - Round-robin grant starts at rr_ptr; the search is combinational.
  - cdb_valid_out = any candidate.
  - cdb_data_out = alu_data_in of the granted slot; cdb_rob_ix_out = the granted slot's latched tag.
  - CDB fire = cdb_valid_out && cdb_ready_in.
  - On fire: alu_read_out[grant]=1 combinationally for that cycle, and rr_ptr <= grant+1 mod NUM_ALU.
  - With no fire, rr_ptr holds and outputs are held stable (no grant change while cdb_ready_in=0 and the granted slot stays valid).
- Latency: issue fire at cycle t gives alu_valid_out at t+1. The result appears on the CDB the cycle the ALU raises valid_out.
- Simultaneous events:
  - Issue and writeback in the same cycle are legal and always involve different slots.
  - A slot entering IDLE is not eligible until the next cycle.
- Reset or flush (synchronous, same behaviour for both):
  - All slots go to IDLE, rr_ptr=0, slot registers are cleared to 0.
  - alu_valid_out=0, alu_read_out=0, cdb_valid_out=0, issue_ready_out=0 in that cycle.
  - A flush mid-BUSY or mid-DRAIN abandons the slot; the top flushes the ALUs the same cycle.
- Unused slot payloads drive 0 on alu_*_out.

Optional Feature:
- Macro ALU_POOL_SCHED_PERF_EN.
- When defined: adds outputs perf_issued_out[31:0] (counts issue fires) and perf_stall_out[31:0] (counts cycles with issue_valid_in=1 && issue_ready_out=0). Both counters clear on rst_in only, not on flush, and wrap at 2^32.
- When undefined: the ports and counters are absent.

Decomposition:
- types.svh gains SlotState enum {SLOT_IDLE, SLOT_LAUNCH, SLOT_BUSY, SLOT_DRAIN} alongside the existing AluFunc.
- One sub-module, alu_rr_arbiter (parameter N; inputs req[N], ptr; output grant one-hot and grant_ix), is instantiated once for writeback.

Test Plan:
- Reset, then issue Add 5,7 tag 1 with cdb_ready_in=1: alu_valid_out[0] pulses once; when the model ALU completes, CDB shows data 12 tag 1 and alu_read_out[0] pulses; slot 0 returns to IDLE after alu_ready_in[0].
- Issue 4 back-to-back ops with NUM_ALU=4: slots 0..3 are filled in order; a 5th op sees issue_ready_out=0 until a slot drains.
- All 4 ALUs valid together, cdb_ready_in=1: grants go 0,1,2,3 in consecutive cycles. Next, slots 2 and 0 valid: grant goes to 0 first only if rr_ptr wrapped; check rr_ptr=0 -> 0 then 2.
- cdb_ready_in=0 for 5 cycles with slot 1 valid: cdb outputs hold (data and tag stable) and alu_read_out stays 0; release -> exactly one read pulse.
- flush_in while slots 0 and 2 are BUSY and an issue is presented: no fire, and next cycle all slots are IDLE with cdb_valid_out=0.
- With ALU_POOL_SCHED_PERF_EN: 3 fires and 2 stalled cycles -> perf_issued_out=3, perf_stall_out=2; a flush leaves both unchanged.
